rc4_encrypt: RTL and testbench
==============================

# rc4_encrypt

Length-prefixed RC4 encryptor: the writer of ciphertext memory, the counterpart of the existing decrypt/key-search path. It reads a plaintext message from plaintext memory, runs KSA then PRGA on an external 256x8 state memory using a 24-bit key, and writes the length-prefixed ciphertext. The result can be loaded as a ciphertext image for the decrypt tasks. It sits beside the arc4 decrypt datapath and drives its own three single-port synchronous RAMs: s, pt and ct.

## Interface
- No parameters; key width is 24, memories are 256x8.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request; accepted only while rdy=1
- rdy  out  1  idle/ready; reset value 1
- key  in  24  key[23:16]=byte0, key[15:8]=byte1, key[7:0]=byte2; sampled on the accept edge
- s_addr  out  8  state-memory address; reset 0
- s_rddata  in  8  state-memory read data, valid 1 cycle after the address
- s_wrdata  out  8  state-memory write data; reset 0
- s_wren  out  1  state-memory write enable; reset 0
- pt_addr  out  8  plaintext address; reset 0
- pt_rddata  in  8  plaintext data, 1-cycle latency
- ct_addr  out  8  ciphertext address; reset 0
- ct_wrdata  out  8  ciphertext data; reset 0
- ct_wren  out  1  ciphertext write enable; reset 0

## Operation
- States: IDLE → INIT → KSA → LEN → PRGA → DONE → IDLE.
- **IDLE:** rdy=1, no writes. en=1 at a clock edge latches the key, clears i/j, and moves to INIT. en is ignored in every other state.
- **INIT:** writes s[i]=i for i=0..255, one write per cycle.
- **KSA:** runs for i=0..255, 5 cycles per iteration.
  - c1: read s[i].
  - c2: capture si; j=j+si+keybyte[i mod 3] (mod 256); read s[j].
  - c3: capture sj.
  - c4: write s[i]=sj.
  - c5: write s[j]=si.
- **LEN:**
  - c1: read pt[0].
  - c2: capture L; write ct[0]=L.
  - Clear i and j to 0.
- **PRGA:** runs for k=1..L, 6 cycles per byte.
  - c1: i=i+1; read s[i].
  - c2: capture si; j=j+si; read s[j].
  - c3: capture sj; write s[i]=sj.
  - c4: write s[j]=si; read pt[k].
  - c5: capture ptk; read s[(si+sj) mod 256].
  - c6: write ct[k]=ptk^pad.
  - The pad read happens after both swap writes, so it sees post-swap contents, including when si+sj equals i or j.
- **DONE:** one cycle with no writes, then IDLE.
- **Arithmetic:** all index arithmetic is 8-bit and wraps mod 256 (i=255+1→0). The key-byte index uses a mod-3 counter, not a divide.
- **L=0:** PRGA is skipped; only ct[0]=0 is written.
- Addresses/data not listed for a cycle hold their last value. wren is high only in the write cycles listed above, and at most one write per memory per cycle.
- **Reset mid-operation:** immediate return to IDLE with all outputs at reset values. Memory contents are not restored. A new en starts a full run from INIT.

## Timing
- Accept edge E0.
- INIT writes occur on edges E1..E256.
- KSA occupies E257..E1536.
- LEN occupies E1537..E1538.
- PRGA occupies E1539..E1538+6L.
- DONE is the next cycle; rdy goes high after edge E1539+6L. Total busy time is 1539+6L cycles.
- rdy drops after E0. rdy is registered, not combinational from en.
- en held high continuously restarts the block immediately after each DONE (back-to-back runs).

## Structure
- rc4_pkg holds:
  - the state enum;
  - constants S_SIZE=256, KEY_BYTES=3, INIT_CYCLES=256, KSA_CYC=5, PRGA_CYC=6;
  - a keybyte(key, idx) function.
- Single module; no sub-module. The FSM and datapath total roughly 250 lines.
- Memories are instantiated by the enclosing top (task-level wrapper), not inside this block.

## Test plan
- Known vector, with behavioural synchronous RAM models:
  - Stimulus: key=24'h4B6579 ("Key"); pt = 09 followed by "Plaintext".
  - Required ct = 09 BB F3 16 E8 D9 40 AF 0A D3.
  - Required rdy high 1539+54=1593 cycles after accept.
- L=0:
  - Required: only ct[0]=0 written; no other ct_wren pulses; rdy back after 1539 cycles.
- Round trip:
  - Stimulus: key=24'h000018, 255-byte random pt; feed the resulting ct into the existing arc4 decrypt with the same key.
  - Required: decrypted output equals pt byte-for-byte.
- Protocol:
  - en pulsed while busy → ignored; run count and ct unchanged.
  - en held high → second run starts on the cycle after DONE and produces identical ct.
  - key changed after accept → output still matches the accepted key.
- Reset mid-PRGA:
  - Stimulus: assert rst_n=0 at cycle 1545.
  - Required: rdy=1 and all wren=0 asynchronously.
  - Then a fresh run with key 4B6579 reproduces the known-vector ct exactly.
- Write-trace check:
  - INIT: exactly 256 s writes with s_addr==s_wrdata.
  - KSA: 512 s writes.
  - PRGA: 2L s writes.
  - L+1 ct writes, at addresses 0..L in order.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types, sizing constants and the key-byte selector for the RC4 encryptor.
package rc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_LEN,
    ST_PRGA,
    ST_DONE
  } state_t;

  localparam int S_SIZE      = 256;
  localparam int KEY_BYTES   = 3;
  localparam int INIT_CYCLES = 256;
  localparam int KSA_CYC     = 5;
  localparam int PRGA_CYC    = 6;

  // Key byte 0 is the most significant byte of the 24-bit key.
  function automatic logic [7:0] keybyte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    return key[23:16];
      2'd1:    return key[15:8];
      default: return key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rc4_encrypt.sv
// Length-prefixed RC4 encryptor: fills the external S-box, runs KSA and PRGA,
// and writes ct[0]=L followed by L ciphertext bytes.
//
// state | meaning
// IDLE  | rdy=1, waiting for en; key latched on accept
// INIT  | s[i]=i for i=0..255, one write per cycle
// KSA   | key schedule, 5 cycles per i (read, read, capture, swap, swap)
// LEN   | read pt[0], write it to ct[0]
// PRGA  | 6 cycles per byte: swap, then pad read after both swap writes
// DONE  | one quiet cycle before returning to IDLE
//
// Read data arrives one cycle after the address, so the cycle that captures a
// read may steer the next address combinationally from the read data. Address
// and data outputs hold their last driven value outside the cycles that use them.
module rc4_encrypt
  import rc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  state_t      state, state_n;
  logic [2:0]  ph, ph_n;
  logic [7:0]  i, i_n, j, j_n, k, k_n, len, len_n;
  logic [7:0]  si, si_n, sj, sj_n, ptk, ptk_n;
  logic [1:0]  kidx, kidx_n;
  logic [23:0] key_q, key_n;
  logic        rdy_q;
  logic [7:0]  s_addr_q, s_wrdata_q, pt_addr_q, ct_addr_q, ct_wrdata_q;

  assign rdy = rdy_q;

  // Next-state, datapath updates and memory port drive for the current cycle.
  always_comb begin
    state_n   = state;
    ph_n      = ph;
    i_n       = i;
    j_n       = j;
    k_n       = k;
    len_n     = len;
    si_n      = si;
    sj_n      = sj;
    ptk_n     = ptk;
    kidx_n    = kidx;
    key_n     = key_q;
    s_addr    = s_addr_q;
    s_wrdata  = s_wrdata_q;
    s_wren    = 1'b0;
    pt_addr   = pt_addr_q;
    ct_addr   = ct_addr_q;
    ct_wrdata = ct_wrdata_q;
    ct_wren   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (en) begin
          key_n   = key;
          i_n     = 8'd0;
          j_n     = 8'd0;
          kidx_n  = 2'd0;
          ph_n    = 3'd0;
          state_n = ST_INIT;
        end
      end

      ST_INIT: begin
        s_addr   = i;
        s_wrdata = i;
        s_wren   = 1'b1;
        i_n      = i + 8'd1;
        if (i == 8'(INIT_CYCLES - 1)) state_n = ST_KSA;
      end

      ST_KSA: begin
        ph_n = (ph == 3'(KSA_CYC - 1)) ? 3'd0 : ph + 3'd1;
        case (ph)
          3'd0: s_addr = i;
          3'd1: begin
            si_n   = s_rddata;
            j_n    = j + s_rddata + keybyte(key_q, kidx);
            s_addr = j_n;
          end
          3'd2: sj_n = s_rddata;
          3'd3: begin
            s_addr   = i;
            s_wrdata = sj;
            s_wren   = 1'b1;
          end
          default: begin
            s_addr   = j;
            s_wrdata = si;
            s_wren   = 1'b1;
            i_n      = i + 8'd1;
            kidx_n   = (kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx + 2'd1;
            if (i == 8'(S_SIZE - 1)) state_n = ST_LEN;
          end
        endcase
      end

      ST_LEN: begin
        if (ph == 3'd0) begin
          pt_addr = 8'd0;
          ph_n    = 3'd1;
        end else begin
          len_n     = pt_rddata;
          ct_addr   = 8'd0;
          ct_wrdata = pt_rddata;
          ct_wren   = 1'b1;
          i_n       = 8'd0;
          j_n       = 8'd0;
          k_n       = 8'd1;
          ph_n      = 3'd0;
          state_n   = (pt_rddata == 8'd0) ? ST_DONE : ST_PRGA;
        end
      end

      ST_PRGA: begin
        ph_n = (ph == 3'(PRGA_CYC - 1)) ? 3'd0 : ph + 3'd1;
        case (ph)
          3'd0: begin
            i_n    = i + 8'd1;
            s_addr = i_n;
          end
          3'd1: begin
            si_n   = s_rddata;
            j_n    = j + s_rddata;
            s_addr = j_n;
          end
          3'd2: begin
            sj_n     = s_rddata;
            s_addr   = i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
          end
          3'd3: begin
            s_addr   = j;
            s_wrdata = si;
            s_wren   = 1'b1;
            pt_addr  = k;
          end
          3'd4: begin
            ptk_n  = pt_rddata;
            s_addr = si + sj;
          end
          default: begin
            ct_addr   = k;
            ct_wrdata = ptk ^ s_rddata;
            ct_wren   = 1'b1;
            k_n       = k + 8'd1;
            if (k == len) state_n = ST_DONE;
          end
        endcase
      end

      ST_DONE: state_n = ST_IDLE;

      default: state_n = ST_IDLE;
    endcase
  end

  // State, datapath registers, held port values and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ph          <= 3'd0;
      i           <= 8'd0;
      j           <= 8'd0;
      k           <= 8'd0;
      len         <= 8'd0;
      si          <= 8'd0;
      sj          <= 8'd0;
      ptk         <= 8'd0;
      kidx        <= 2'd0;
      key_q       <= 24'd0;
      rdy_q       <= 1'b1;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
    end else begin
      state       <= state_n;
      ph          <= ph_n;
      i           <= i_n;
      j           <= j_n;
      k           <= k_n;
      len         <= len_n;
      si          <= si_n;
      sj          <= sj_n;
      ptk         <= ptk_n;
      kidx        <= kidx_n;
      key_q       <= key_n;
      rdy_q       <= (state_n == ST_IDLE);
      s_addr_q    <= s_addr;
      s_wrdata_q  <= s_wrdata;
      pt_addr_q   <= pt_addr;
      ct_addr_q   <= ct_addr;
      ct_wrdata_q <= ct_wrdata;
    end
  end

endmodule

// File: tb/tb_rc4_encrypt.sv
// Bench for rc4_encrypt: behavioural synchronous RAMs, a reference RC4 model
// feeding an expected-ciphertext queue, and a monitor of all memory writes.
module tb_rc4_encrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy;
  logic [23:0] key = 24'd0;
  logic [7:0]  s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic        s_wren, ct_wren;

  int total = 0;
  int bad = 0;

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem[256];
  logic [7:0] exp_q[$];
  logic [7:0] obs_a[$];
  logic [7:0] obs_d[$];
  int run_cyc = 0;
  int n_init = 0, init_bad = 0, n_ksa = 0, n_prga = 0;
  logic rdy_after_accept;

  localparam logic [23:0] KV_KEY = 24'h4B6579;
  logic [7:0] kv_pt[9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] kv_ct[10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  always #5 clk = ~clk;

  rc4_encrypt dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  // Single-port synchronous RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
  end

  // Write monitor: ciphertext trace plus S-box write counts per run phase.
  always @(negedge clk) begin
    if (ct_wren) begin
      obs_a.push_back(ct_addr);
      obs_d.push_back(ct_wrdata);
    end
    if (s_wren) begin
      if (run_cyc < 256) begin
        n_init++;
        if (s_addr !== s_wrdata) init_bad++;
      end else if (run_cyc < 1536) n_ksa++;
      else n_prga++;
    end
  end

  task automatic load_random(input int len);
    pt_mem[0] = 8'(len);
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
  endtask

  task automatic load_known();
    pt_mem[0] = 8'd9;
    for (int n = 0; n < 9; n++) pt_mem[n+1] = kv_pt[n];
  endtask

  // Reference RC4 over the current plaintext image; pushes ct[0..L].
  task automatic push_expected(input logic [23:0] k);
    int sb[256];
    int kb[3];
    int i, j, t, len;
    kb[0] = int'(k[23:16]);
    kb[1] = int'(k[15:8]);
    kb[2] = int'(k[7:0]);
    for (int n = 0; n < 256; n++) sb[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + sb[n] + kb[n % 3]) & 255;
      t = sb[n]; sb[n] = sb[j]; sb[j] = t;
    end
    len = int'(pt_mem[0]);
    exp_q.push_back(pt_mem[0]);
    i = 0;
    j = 0;
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) & 255;
      j = (j + sb[i]) & 255;
      t = sb[i]; sb[i] = sb[j]; sb[j] = t;
      exp_q.push_back(8'(sb[(sb[i] + sb[j]) & 255]) ^ pt_mem[n]);
    end
  endtask

  task automatic start_run(input logic [23:0] k);
    @(negedge clk);
    key = k;
    en = 1'b1;
    @(posedge clk);
    run_cyc = 0;
    #1 rdy_after_accept = rdy;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = -1;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      run_cyc++;
      #1;
      if (rdy) begin
        cyc = run_cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (rdy !== 1'b1) begin
      bad++; $display("FAIL reset_rdy: got %b want 1", rdy);
    end
    total++;
    if ({s_wren, ct_wren} !== 2'b00) begin
      bad++; $display("FAIL reset_wren: got %b want 00", {s_wren, ct_wren});
    end
    total++;
    if ({s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata} !== 40'h0) begin
      bad++; $display("FAIL reset_ports: got %h want 0", {s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_known_vector();
    int cyc, m0, i0, k0, p0, b0;
    logic [7:0] e, ga, gd;
    load_known();
    m0 = obs_d.size(); i0 = n_init; k0 = n_ksa; p0 = n_prga; b0 = init_bad;
    push_expected(KV_KEY);
    start_run(KV_KEY);
    wait_rdy(cyc);
    total++;
    if (rdy_after_accept !== 1'b0) begin
      bad++; $display("FAIL kv_rdy_drop: got %b want 0", rdy_after_accept);
    end
    total++;
    if (cyc != 1593) begin
      bad++; $display("FAIL kv_busy: got %0d want 1593", cyc);
    end
    total++;
    if (obs_d.size() - m0 != 10) begin
      bad++; $display("FAIL kv_ct_count: got %0d want 10", obs_d.size() - m0);
    end
    for (int n = 0; n < 10; n++) begin
      e  = exp_q.pop_front();
      ga = (m0 + n < obs_a.size()) ? obs_a[m0+n] : 8'hxx;
      gd = (m0 + n < obs_d.size()) ? obs_d[m0+n] : 8'hxx;
      total++;
      if (ga !== 8'(n) || gd !== e || gd !== kv_ct[n]) begin
        bad++; $display("FAIL kv_ct[%0d]: got addr %0d data %h want addr %0d data %h", n, ga, gd, n, kv_ct[n]);
      end
    end
    total++;
    if (n_init - i0 != 256 || init_bad - b0 != 0) begin
      bad++; $display("FAIL kv_init_trace: got %0d writes %0d addr!=data want 256 and 0", n_init - i0, init_bad - b0);
    end
    total++;
    if (n_ksa - k0 != 512) begin
      bad++; $display("FAIL kv_ksa_trace: got %0d want 512", n_ksa - k0);
    end
    total++;
    if (n_prga - p0 != 18) begin
      bad++; $display("FAIL kv_prga_trace: got %0d want 18", n_prga - p0);
    end
  endtask

  task automatic test_len_zero();
    int cyc, m0, p0;
    logic [7:0] e, ga, gd;
    load_random(0);
    m0 = obs_d.size(); p0 = n_prga;
    push_expected(KV_KEY);
    start_run(KV_KEY);
    wait_rdy(cyc);
    total++;
    if (cyc != 1539) begin
      bad++; $display("FAIL l0_busy: got %0d want 1539", cyc);
    end
    total++;
    if (obs_d.size() - m0 != 1 || n_prga - p0 != 0) begin
      bad++; $display("FAIL l0_writes: got ct %0d s_prga %0d want 1 and 0", obs_d.size() - m0, n_prga - p0);
    end
    e  = exp_q.pop_front();
    ga = (m0 < obs_a.size()) ? obs_a[m0] : 8'hxx;
    gd = (m0 < obs_d.size()) ? obs_d[m0] : 8'hxx;
    total++;
    if (ga !== 8'd0 || gd !== e || gd !== 8'd0) begin
      bad++; $display("FAIL l0_ct0: got addr %0d data %h want addr 0 data 00", ga, gd);
    end
  endtask

  task automatic test_key_change();
    int cyc, m0;
    logic [23:0] k;
    logic [7:0] e, ga, gd;
    k = 24'($urandom);
    load_random(20);
    m0 = obs_d.size();
    push_expected(k);
    start_run(k);
    key = ~k;
    wait_rdy(cyc);
    total++;
    if (cyc != 1539 + 6 * 20) begin
      bad++; $display("FAIL kc_busy: got %0d want %0d", cyc, 1539 + 6 * 20);
    end
    for (int n = 0; n <= 20; n++) begin
      e  = exp_q.pop_front();
      ga = (m0 + n < obs_a.size()) ? obs_a[m0+n] : 8'hxx;
      gd = (m0 + n < obs_d.size()) ? obs_d[m0+n] : 8'hxx;
      total++;
      if (ga !== 8'(n) || gd !== e) begin
        bad++; $display("FAIL kc_ct[%0d]: got addr %0d data %h want addr %0d data %h", n, ga, gd, n, e);
      end
    end
  endtask

  task automatic test_busy_en();
    int cyc, m0;
    logic [7:0] e, ga, gd;
    load_random(5);
    m0 = obs_d.size();
    push_expected(24'hA5C311);
    start_run(24'hA5C311);
    cyc = -1;
    // en pulses land in INIT, KSA, PRGA and the DONE cycle
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      run_cyc++;
      #1;
      en = (run_cyc == 10 || run_cyc == 800 || run_cyc == 1540 || run_cyc == 1568);
      if (rdy) begin
        cyc = run_cyc;
        break;
      end
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (cyc != 1569 || rdy !== 1'b1) begin
      bad++; $display("FAIL busy_en_cycles: got %0d rdy %b want 1569 rdy 1", cyc, rdy);
    end
    total++;
    if (obs_d.size() - m0 != 6) begin
      bad++; $display("FAIL busy_en_count: got %0d want 6", obs_d.size() - m0);
    end
    for (int n = 0; n <= 5; n++) begin
      e  = exp_q.pop_front();
      ga = (m0 + n < obs_a.size()) ? obs_a[m0+n] : 8'hxx;
      gd = (m0 + n < obs_d.size()) ? obs_d[m0+n] : 8'hxx;
      total++;
      if (ga !== 8'(n) || gd !== e) begin
        bad++; $display("FAIL busy_en_ct[%0d]: got addr %0d data %h want addr %0d data %h", n, ga, gd, n, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2, m0;
    logic r2;
    logic [7:0] e, ga, gd;
    load_random(4);
    m0 = obs_d.size();
    push_expected(24'h123456);
    push_expected(24'h123456);
    @(negedge clk);
    key = 24'h123456;
    en = 1'b1;
    @(posedge clk);
    run_cyc = 0;
    c1 = -1;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      run_cyc++;
      #1;
      if (rdy) begin
        c1 = run_cyc;
        break;
      end
    end
    @(posedge clk);
    run_cyc = 0;
    #1 r2 = rdy;
    @(negedge clk);
    en = 1'b0;
    wait_rdy(c2);
    total++;
    if (c1 != 1563 || c2 != 1563 || r2 !== 1'b0) begin
      bad++; $display("FAIL b2b_timing: got %0d %0d restart_rdy %b want 1563 1563 0", c1, c2, r2);
    end
    for (int n = 0; n < 10; n++) begin
      e  = exp_q.pop_front();
      ga = (m0 + n < obs_a.size()) ? obs_a[m0+n] : 8'hxx;
      gd = (m0 + n < obs_d.size()) ? obs_d[m0+n] : 8'hxx;
      total++;
      if (ga !== 8'(n % 5) || gd !== e) begin
        bad++; $display("FAIL b2b_ct[%0d]: got addr %0d data %h want addr %0d data %h", n, ga, gd, n % 5, e);
      end
    end
  endtask

  task automatic test_round_trip();
    int cyc, m0, m1;
    logic [7:0] orig[256];
    logic [7:0] e, ga, gd;
    load_random(255);
    for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
    m0 = obs_d.size();
    push_expected(24'h000018);
    start_run(24'h000018);
    wait_rdy(cyc);
    total++;
    if (cyc != 1539 + 6 * 255) begin
      bad++; $display("FAIL rt_busy: got %0d want %0d", cyc, 1539 + 6 * 255);
    end
    for (int n = 0; n < 256; n++) begin
      e  = exp_q.pop_front();
      ga = (m0 + n < obs_a.size()) ? obs_a[m0+n] : 8'hxx;
      gd = (m0 + n < obs_d.size()) ? obs_d[m0+n] : 8'hxx;
      pt_mem[n] = gd;
      total++;
      if (ga !== 8'(n) || gd !== e) begin
        bad++; $display("FAIL rt_enc[%0d]: got addr %0d data %h want addr %0d data %h", n, ga, gd, n, e);
      end
    end
    // Re-encrypting the ciphertext image with the same key must yield the plaintext.
    for (int n = 0; n < 256; n++) exp_q.push_back(orig[n]);
    m1 = obs_d.size();
    start_run(24'h000018);
    wait_rdy(cyc);
    for (int n = 0; n < 256; n++) begin
      e  = exp_q.pop_front();
      gd = (m1 + n < obs_d.size()) ? obs_d[m1+n] : 8'hxx;
      total++;
      if (gd !== e) begin
        bad++; $display("FAIL rt_dec[%0d]: got %h want %h", n, gd, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, m0;
    logic pre_wren;
    logic [7:0] e, ga, gd;
    load_known();
    start_run(KV_KEY);
    // stop inside PRGA on a swap-write cycle
    pre_wren = 1'b0;
    for (int n = 0; n < 1546; n++) begin
      @(posedge clk);
      run_cyc++;
      #1;
      if (run_cyc == 1546) break;
    end
    pre_wren = s_wren;
    rst_n = 1'b0;
    #1;
    total++;
    if (pre_wren !== 1'b1) begin
      bad++; $display("FAIL mid_pre_wren: got %b want 1", pre_wren);
    end
    total++;
    if (rdy !== 1'b1 || s_wren !== 1'b0 || ct_wren !== 1'b0) begin
      bad++; $display("FAIL mid_async: got rdy %b s_wren %b ct_wren %b want 1 0 0", rdy, s_wren, ct_wren);
    end
    total++;
    if ({s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata} !== 40'h0) begin
      bad++; $display("FAIL mid_ports: got %h want 0", {s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m0 = obs_d.size();
    push_expected(KV_KEY);
    start_run(KV_KEY);
    wait_rdy(cyc);
    total++;
    if (cyc != 1593) begin
      bad++; $display("FAIL mid_rerun_busy: got %0d want 1593", cyc);
    end
    for (int n = 0; n < 10; n++) begin
      e  = exp_q.pop_front();
      ga = (m0 + n < obs_a.size()) ? obs_a[m0+n] : 8'hxx;
      gd = (m0 + n < obs_d.size()) ? obs_d[m0+n] : 8'hxx;
      total++;
      if (ga !== 8'(n) || gd !== kv_ct[n] || gd !== e) begin
        bad++; $display("FAIL mid_rerun_ct[%0d]: got addr %0d data %h want addr %0d data %h", n, ga, gd, n, kv_ct[n]);
      end
    end
  endtask

  initial begin
    for (int n = 0; n < 256; n++) begin
      s_mem[n]  = 8'd0;
      pt_mem[n] = 8'd0;
    end
    test_reset();
    test_known_vector();
    test_len_zero();
    test_key_change();
    test_busy_en();
    test_back_to_back();
    test_round_trip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
